// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared constants and types for the multi-cycle RV32I core
package riscv_mc_pkg;

   // Major opcodes of the supported subset
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // funct3 values for ALU, branch and store groups
   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_SLL = 3'd1;
   localparam logic [2:0] F3_SLT = 3'd2;
   localparam logic [2:0] F3_XOR = 3'd4;
   localparam logic [2:0] F3_SR  = 3'd5;
   localparam logic [2:0] F3_OR  = 3'd6;
   localparam logic [2:0] F3_AND = 3'd7;
   localparam logic [2:0] F3_BEQ = 3'd0;
   localparam logic [2:0] F3_BNE = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // funct7 pattern selecting SUB / SRA / SRAI
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // ECALL is recognised only as the exact canonical encoding
   localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_HALT
   } state_t;

   typedef enum logic [1:0] {
      TRAP_NONE     = 2'd0,
      TRAP_ECALL    = 2'd1,
      TRAP_ILLEGAL  = 2'd2,
      TRAP_MISALIGN = 2'd3
   } trap_t;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASS_B
   } alu_op_t;

   // Sign-extend a 12-bit immediate field to 32 bits
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/riscv_mc_alu.sv
// rtl/riscv_mc_alu.sv - combinational 32-bit ALU for the multi-cycle core
module riscv_mc_alu
   import riscv_mc_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     alu_op,
   output logic [31:0] result
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   // Select the operation; shifts use only the low five bits of b
   always_comb begin
      result = 32'd0;
      case (alu_op)
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_SLL:    result = a << shamt;
         ALU_SLT:    result = {31'd0, ($signed(a) < $signed(b))};
         ALU_XOR:    result = a ^ b;
         ALU_SRL:    result = a >> shamt;
         ALU_SRA:    result = 32'($signed(a) >>> shamt);
         ALU_OR:     result = a | b;
         ALU_AND:    result = a & b;
         ALU_PASS_B: result = b;
         default:    result = 32'd0;
      endcase
   end

endmodule

// File: rtl/riscv_mc_core.sv
// rtl/riscv_mc_core.sv - four-cycle RV32I-subset core with load port and GPIO register
module riscv_mc_core
   import riscv_mc_pkg::*;
#(
   parameter int          IMEM_DEPTH = 64,
   parameter int          GPIO_W     = 8,
   parameter logic [31:0] GPIO_ADDR  = 32'h0000_1000,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   output logic [GPIO_W-1:0]             gpio,
   output logic                          retire,
   output logic                          halted,
   output logic [1:0]                    trap_cause,
   output logic [31:0]                   pc_out
);

   localparam int AW = $clog2(IMEM_DEPTH);

   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] regs [32];

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] imm_q;
   logic [31:0] res_q;
   logic [31:0] target_q;
   logic        taken_q;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   logic [31:0] imm_d;
   alu_op_t     alu_op;
   logic        use_imm;
   logic        wr_rd;
   logic        is_store;
   logic        is_branch;
   logic        is_jal;
   logic        is_ecall;
   logic        illegal;
   trap_t       trap_sel;

   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic [31:0] pc_plus4;
   logic [31:0] wb_data;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        branch_eq;

   logic        fetch_go;
   logic        rf_we;
   logic        gpio_we;
   logic        pc_we;
   logic        trap_we;

   assign opcode   = ir[6:0];
   assign rd       = ir[11:7];
   assign funct3   = ir[14:12];
   assign rs1      = ir[19:15];
   assign rs2      = ir[24:20];
   assign funct7   = ir[31:25];

   assign fetch_go = run && !halted;
   assign pc_plus4 = pc + 32'd4;
   assign wb_data  = is_jal ? pc_plus4 : res_q;
   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
   assign alu_b    = use_imm ? imm_q : op_b;
   assign branch_eq = (op_a == op_b);
   assign pc_out   = pc;

   riscv_mc_alu u_alu (
      .a      (op_a),
      .b      (alu_b),
      .alu_op (alu_op),
      .result (alu_y)
   );

   // Load port: host writes land only while the core is parked
   always_ff @(posedge clk) begin
      if (imem_we && !run)
         imem[imem_waddr] <= imem_wdata;
   end

   // Decode the latched instruction into immediate, ALU op and class flags
   always_comb begin
      imm_d     = sext12(ir[31:20]);
      alu_op    = ALU_ADD;
      use_imm   = 1'b0;
      wr_rd     = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_ecall  = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            use_imm = 1'b1;
            wr_rd   = 1'b1;
            case (funct3)
               F3_ADD: alu_op = ALU_ADD;
               F3_SLT: alu_op = ALU_SLT;
               F3_XOR: alu_op = ALU_XOR;
               F3_OR:  alu_op = ALU_OR;
               F3_AND: alu_op = ALU_AND;
               F3_SLL: begin
                  alu_op  = ALU_SLL;
                  illegal = (funct7 != F7_BASE);
               end
               F3_SR: begin
                  alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                  illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
               end
               default: illegal = 1'b1;
            endcase
         end
         OPC_OP: begin
            wr_rd = 1'b1;
            case (funct3)
               F3_ADD:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
               F3_SLL:  alu_op = ALU_SLL;
               F3_SLT:  alu_op = ALU_SLT;
               F3_XOR:  alu_op = ALU_XOR;
               F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
               F3_OR:   alu_op = ALU_OR;
               F3_AND:  alu_op = ALU_AND;
               default: illegal = 1'b1;
            endcase
            // Only ADD/SUB and SRL/SRA have an alternate funct7
            if (!((funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))))
               illegal = 1'b1;
         end
         OPC_LUI: begin
            imm_d   = {ir[31:12], 12'd0};
            alu_op  = ALU_PASS_B;
            use_imm = 1'b1;
            wr_rd   = 1'b1;
         end
         OPC_JAL: begin
            imm_d  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            is_jal = 1'b1;
            wr_rd  = 1'b1;
         end
         OPC_BRANCH: begin
            imm_d     = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            is_branch = 1'b1;
            illegal   = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
         end
         OPC_STORE: begin
            imm_d    = sext12({ir[31:25], ir[11:7]});
            use_imm  = 1'b1;
            is_store = 1'b1;
            illegal  = (funct3 != F3_SW);
         end
         OPC_SYSTEM: begin
            is_ecall = (ir == INSN_ECALL);
            illegal  = (ir != INSN_ECALL);
         end
         default: illegal = 1'b1;
      endcase
   end

   // Trap priority at writeback: illegal, then ECALL, then a misaligned taken target
   always_comb begin
      trap_sel = TRAP_NONE;
      if (illegal)
         trap_sel = TRAP_ILLEGAL;
      else if (is_ecall)
         trap_sel = TRAP_ECALL;
      else if (taken_q && (target_q[1:0] != 2'b00))
         trap_sel = TRAP_MISALIGN;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_FETCH;
      else
         state <= state_nxt;
   end

   // FSM next-state: four steps per instruction, any trap parks in HALT
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH:     if (fetch_go) state_nxt = ST_DECODE;
         ST_DECODE:    state_nxt = ST_EXECUTE;
         ST_EXECUTE:   state_nxt = ST_WRITEBACK;
         ST_WRITEBACK: state_nxt = (trap_sel != TRAP_NONE) ? ST_HALT : ST_FETCH;
         ST_HALT:      state_nxt = ST_HALT;
         default:      state_nxt = ST_FETCH;
      endcase
   end

   // FSM outputs: writeback enables and the retire pulse
   always_comb begin
      retire  = 1'b0;
      trap_we = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      gpio_we = 1'b0;
      if (state == ST_WRITEBACK) begin
         retire  = (trap_sel == TRAP_NONE) || (trap_sel == TRAP_ECALL);
         trap_we = (trap_sel != TRAP_NONE);
         pc_we   = (trap_sel == TRAP_NONE);
         rf_we   = pc_we && wr_rd && (rd != 5'd0);
         gpio_we = pc_we && is_store && (res_q == GPIO_ADDR);
      end
   end

   // Datapath registers advanced stage by stage; reset aborts any instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc         <= RESET_PC;
         ir         <= 32'd0;
         op_a       <= 32'd0;
         op_b       <= 32'd0;
         imm_q      <= 32'd0;
         res_q      <= 32'd0;
         target_q   <= 32'd0;
         taken_q    <= 1'b0;
         gpio       <= '0;
         halted     <= 1'b0;
         trap_cause <= TRAP_NONE;
      end else begin
         if ((state == ST_FETCH) && fetch_go)
            ir <= imem[pc[2 +: AW]];
         if (state == ST_DECODE) begin
            op_a  <= rs1_val;
            op_b  <= rs2_val;
            imm_q <= imm_d;
         end
         if (state == ST_EXECUTE) begin
            res_q    <= alu_y;
            target_q <= pc + imm_q;
            taken_q  <= is_jal ||
                        (is_branch && ((funct3 == F3_BNE) ? !branch_eq : branch_eq));
         end
         if (pc_we)
            pc <= taken_q ? target_q : pc_plus4;
         if (gpio_we)
            gpio <= op_b[GPIO_W-1:0];
         if (trap_we) begin
            halted     <= 1'b1;
            trap_cause <= trap_sel;
         end
      end
   end

   // Register file: x0 is never written so it always reads zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= 32'd0;
      end else if (rf_we) begin
         regs[rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_riscv_mc_core.sv
// tb/tb_riscv_mc_core.sv - directed and random program checks for riscv_mc_core
module tb_riscv_mc_core;

   localparam int          DEPTH  = 64;
   localparam logic [31:0] GPIO_A = 32'h0000_1000;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

   logic        clk;
   logic        reset;
   logic        run;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic [7:0]  gpio;
   logic        retire;
   logic        halted;
   logic [1:0]  trap_cause;
   logic [31:0] pc_out;

   int errors = 0;
   int checks = 0;

   logic [31:0] prog [DEPTH];
   int          n_ret;
   int          ret_cyc [$];
   logic [7:0]  gpio_seq [$];

   logic [31:0] m_x [32];
   logic [31:0] m_pc;
   logic [7:0]  m_gpio;
   int          m_ret;
   logic [1:0]  m_cause;

   riscv_mc_core #(
      .IMEM_DEPTH (DEPTH),
      .GPIO_W     (8),
      .GPIO_ADDR  (GPIO_A),
      .RESET_PC   (32'h0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .gpio       (gpio),
      .retire     (retire),
      .halted     (halted),
      .trap_cause (trap_cause),
      .pc_out     (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'h37};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < DEPTH; i++) prog[i] = ECALL;
   endtask

   task automatic load_prog();
      run = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         imem_we    = 1'b1;
         imem_waddr = 6'(i);
         imem_wdata = prog[i];
      end
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   task automatic do_reset();
      run = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Runs until halted; optionally tries a load-port write while running
   task automatic run_prog(input int budget, input bit poke);
      int         cyc;
      logic [7:0] last;
      cyc  = 0;
      last = gpio;
      n_ret = 0;
      ret_cyc.delete();
      gpio_seq.delete();
      @(negedge clk);
      run = 1'b1;
      if (poke) begin
         imem_we    = 1'b1;
         imem_waddr = 6'd5;
         imem_wdata = ECALL;
      end
      while (!halted && cyc < budget) begin
         @(negedge clk);
         cyc++;
         imem_we = 1'b0;
         if (retire) begin
            n_ret++;
            ret_cyc.push_back(cyc);
         end
         if (gpio !== last) begin
            gpio_seq.push_back(gpio);
            last = gpio;
         end
      end
      check_eq("run_halts_in_budget", {31'd0, halted}, 32'd1);
      run = 1'b0;
   endtask

   // Instruction-set-level model: one loop iteration per architectural instruction
   task automatic model_run();
      logic [31:0] ins, a, b, r, nxt, immi, simm, bimm, jimm;
      logic [4:0]  sh;
      logic [6:0]  f7;
      bit          wr, bad, ecall, done;
      int          steps;
      for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
      m_pc = 32'd0; m_gpio = 8'd0; m_ret = 0; m_cause = 2'd0;
      done = 0; steps = 0;
      while (!done && steps < 5000) begin
         steps++;
         ins  = prog[(m_pc / 4) % DEPTH];
         a    = m_x[ins[19:15]];
         b    = m_x[ins[24:20]];
         f7   = ins[31:25];
         immi = {{20{ins[31]}}, ins[31:20]};
         simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         wr = 0; bad = 0; ecall = 0; r = 32'd0; nxt = m_pc + 4;
         case (ins[6:0])
            7'h13: begin
               wr = 1; sh = ins[24:20];
               case (ins[14:12])
                  3'd0: r = a + immi;
                  3'd2: r = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                  3'd4: r = a ^ immi;
                  3'd6: r = a | immi;
                  3'd7: r = a & immi;
                  3'd1: if (f7 == 7'h00) r = a << sh; else bad = 1;
                  3'd5: if (f7 == 7'h00) r = a >> sh;
                        else if (f7 == 7'h20) r = $signed(a) >>> sh;
                        else bad = 1;
                  default: bad = 1;
               endcase
            end
            7'h33: begin
               wr = 1; sh = b[4:0];
               if (f7 == 7'h00) begin
                  case (ins[14:12])
                     3'd0: r = a + b;
                     3'd1: r = a << sh;
                     3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                     3'd4: r = a ^ b;
                     3'd5: r = a >> sh;
                     3'd6: r = a | b;
                     3'd7: r = a & b;
                     default: bad = 1;
                  endcase
               end else if (f7 == 7'h20) begin
                  case (ins[14:12])
                     3'd0: r = a - b;
                     3'd5: r = $signed(a) >>> sh;
                     default: bad = 1;
                  endcase
               end else bad = 1;
            end
            7'h37: begin wr = 1; r = {ins[31:12], 12'd0}; end
            7'h6f: begin wr = 1; r = m_pc + 4; nxt = m_pc + jimm; end
            7'h63: begin
               if (ins[14:12] == 3'd0)      begin if (a == b) nxt = m_pc + bimm; end
               else if (ins[14:12] == 3'd1) begin if (a != b) nxt = m_pc + bimm; end
               else bad = 1;
            end
            7'h23: begin
               if (ins[14:12] != 3'd2) bad = 1;
               else if (a + simm == GPIO_A) m_gpio = b[7:0];
            end
            7'h73: if (ins == ECALL) ecall = 1; else bad = 1;
            default: bad = 1;
         endcase
         if (bad) begin
            m_cause = 2'd2; done = 1;
         end else if (ecall) begin
            m_cause = 2'd1; m_ret++; done = 1;
         end else if (nxt[1:0] != 2'b00) begin
            m_cause = 2'd3; done = 1;
         end else begin
            if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = r;
            m_ret++;
            m_pc = nxt;
         end
      end
   endtask

   task automatic gen_random_prog();
      int          n, kind, w;
      logic [4:0]  rd, rs1, rs2, sh;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] imm;
      clear_prog();
      prog[0] = enc_u(20'h1, 5'd7);
      n = $urandom_range(8, 20);
      for (int k = 1; k <= n; k++) begin
         kind = $urandom_range(0, 9);
         rd   = 5'($urandom_range(1, 6));
         rs1  = 5'($urandom_range(0, 7));
         rs2  = 5'($urandom_range(0, 7));
         sh   = 5'($urandom);
         imm  = 12'($urandom);
         if (kind <= 3) begin
            case ($urandom_range(0, 6))
               0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd4; 3: f3 = 3'd6;
               4: f3 = 3'd7; 5: f3 = 3'd1; default: f3 = 3'd5;
            endcase
            if (f3 == 3'd1) imm = {7'h00, sh};
            if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sh};
            prog[k] = enc_i(imm, rs1, f3, rd);
         end else if (kind <= 6) begin
            f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'd3) f3 = 3'd0;
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            prog[k] = enc_r(f7, rs2, rs1, f3, rd);
         end else if (kind == 7) begin
            prog[k] = enc_u(20'($urandom), rd);
         end else if (kind == 8) begin
            prog[k] = enc_s(($urandom_range(0, 2) == 0) ? 12'd4 : 12'd0, rs2, 5'd7);
         end else begin
            w = $urandom_range(1, n + 1 - k);
            case ($urandom_range(0, 2))
               0: prog[k] = enc_b(13'(w * 4), rs2, rs1, 3'd0);
               1: prog[k] = enc_b(13'(w * 4), rs2, rs1, 3'd1);
               default: prog[k] = enc_j(21'(w * 4), rd);
            endcase
         end
      end
      prog[n + 1] = ECALL;
   endtask

   initial begin
      int          nr;
      int          cyc;
      logic [7:0]  exp_seq [3];

      reset = 1'b1; run = 1'b0; imem_we = 1'b0; imem_waddr = 6'd0; imem_wdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("reset_pc",     pc_out, 32'd0);
      check_eq("reset_gpio",   {24'd0, gpio}, 32'd0);
      check_eq("reset_retire", {31'd0, retire}, 32'd0);
      check_eq("reset_halted", {31'd0, halted}, 32'd0);
      check_eq("reset_trap",   {30'd0, trap_cause}, 32'd0);

      // Arithmetic plus GPIO store; 0x1000 is out of reach of a 12-bit offset so x5 holds it
      clear_prog();
      prog[0] = enc_i(12'd2, 5'd0, 3'd0, 5'd1);
      prog[1] = enc_i(12'd3, 5'd0, 3'd0, 5'd2);
      prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      prog[3] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
      prog[4] = enc_u(20'h1, 5'd5);
      prog[5] = enc_s(12'd0, 5'd4, 5'd5);
      prog[6] = ECALL;
      load_prog();
      run_prog(400, 1'b1);
      check_eq("t1_gpio",    {24'd0, gpio}, 32'h0000_00FF);
      check_eq("t1_x3",      dut.regs[3], 32'd5);
      check_eq("t1_x4",      dut.regs[4], 32'hFFFF_FFFF);
      check_eq("t1_retires", n_ret, 32'd7);
      for (int i = 1; i < ret_cyc.size(); i++)
         check_eq($sformatf("t1_retire_gap%0d", i), ret_cyc[i] - ret_cyc[i-1], 32'd4);
      check_eq("t1_halted",  {31'd0, halted}, 32'd1);
      check_eq("t1_trap",    {30'd0, trap_cause}, 32'd1);
      check_eq("t1_pc",      pc_out, 32'd24);

      // Shifts of a negative value
      do_reset();
      clear_prog();
      prog[0] = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1);
      prog[1] = enc_i({7'h20, 5'd1}, 5'd1, 3'd5, 5'd2);
      prog[2] = enc_i(12'd28, 5'd1, 3'd5, 5'd3);
      load_prog();
      run_prog(400, 1'b0);
      check_eq("t2_x1", dut.regs[1], 32'hFFFF_FFFB);
      check_eq("t2_x2", dut.regs[2], 32'hFFFF_FFFD);
      check_eq("t2_x3", dut.regs[3], 32'h0000_000F);

      // Writes to x0 are discarded
      do_reset();
      clear_prog();
      prog[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
      prog[1] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
      load_prog();
      run_prog(400, 1'b0);
      check_eq("t3_x1", dut.regs[1], 32'd0);
      check_eq("t3_x0", dut.regs[0], 32'd0);

      // Countdown loop with a backward BNE
      do_reset();
      clear_prog();
      prog[0] = enc_u(20'h1, 5'd5);
      prog[1] = enc_i(12'd3, 5'd0, 3'd0, 5'd1);
      prog[2] = enc_i(12'hFFF, 5'd1, 3'd0, 5'd1);
      prog[3] = enc_s(12'd0, 5'd1, 5'd5);
      prog[4] = enc_b(13'h1FF8, 5'd0, 5'd1, 3'd1);
      prog[5] = ECALL;
      load_prog();
      run_prog(400, 1'b0);
      exp_seq[0] = 8'd2; exp_seq[1] = 8'd1; exp_seq[2] = 8'd0;
      check_eq("t4_gpio_changes", gpio_seq.size(), 32'd3);
      for (int i = 0; i < 3; i++)
         check_eq($sformatf("t4_gpio_seq%0d", i),
                  (i < gpio_seq.size()) ? {24'd0, gpio_seq[i]} : 32'hDEAD_BEEF,
                  {24'd0, exp_seq[i]});
      check_eq("t4_retires", n_ret, 32'd12);
      check_eq("t4_pc",      pc_out, 32'd20);

      // Illegal word at pc=8
      do_reset();
      clear_prog();
      prog[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
      prog[1] = enc_i(12'd2, 5'd0, 3'd0, 5'd2);
      prog[2] = 32'hFFFF_FFFF;
      load_prog();
      run_prog(400, 1'b0);
      check_eq("t5_trap",    {30'd0, trap_cause}, 32'd2);
      check_eq("t5_pc",      pc_out, 32'd8);
      check_eq("t5_retires", n_ret, 32'd2);
      check_eq("t5_x1",      dut.regs[1], 32'd1);

      // JAL to a misaligned target
      do_reset();
      clear_prog();
      prog[0] = enc_j(21'd2, 5'd1);
      load_prog();
      run_prog(400, 1'b0);
      check_eq("t6_trap", {30'd0, trap_cause}, 32'd3);
      check_eq("t6_pc",   pc_out, 32'd0);
      check_eq("t6_x1",   dut.regs[1], 32'd0);

      // Reset while the ADD is in EXECUTE, then reload and rerun
      do_reset();
      clear_prog();
      prog[0] = enc_i(12'd2, 5'd0, 3'd0, 5'd1);
      prog[1] = enc_i(12'd3, 5'd0, 3'd0, 5'd2);
      prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      load_prog();
      @(negedge clk);
      run = 1'b1;
      nr = 0; cyc = 0;
      while (nr < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (retire) nr++;
      end
      check_eq("t7_two_retires", nr, 32'd2);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      run   = 1'b0;
      #1;
      check_eq("t7_pc",     pc_out, 32'd0);
      check_eq("t7_gpio",   {24'd0, gpio}, 32'd0);
      check_eq("t7_retire", {31'd0, retire}, 32'd0);
      check_eq("t7_halted", {31'd0, halted}, 32'd0);
      check_eq("t7_trap",   {30'd0, trap_cause}, 32'd0);
      check_eq("t7_x3",     dut.regs[3], 32'd0);
      check_eq("t7_x1",     dut.regs[1], 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_prog();
      prog[0] = enc_i(12'd9, 5'd0, 3'd0, 5'd6);
      load_prog();
      run_prog(400, 1'b0);
      check_eq("t7_rerun_x6", dut.regs[6], 32'd9);
      check_eq("t7_rerun_pc", pc_out, 32'd4);
      check_eq("t7_rerun_x3", dut.regs[3], 32'd0);

      // Random programs against the instruction-level model
      for (int t = 0; t < 8; t++) begin
         gen_random_prog();
         do_reset();
         load_prog();
         run_prog(2000, 1'b0);
         model_run();
         for (int i = 1; i < 8; i++)
            check_eq($sformatf("rnd%0d_x%0d", t, i), dut.regs[i], m_x[i]);
         check_eq($sformatf("rnd%0d_gpio", t),    {24'd0, gpio}, {24'd0, m_gpio});
         check_eq($sformatf("rnd%0d_pc", t),      pc_out, m_pc);
         check_eq($sformatf("rnd%0d_trap", t),    {30'd0, trap_cause}, {30'd0, m_cause});
         check_eq($sformatf("rnd%0d_retires", t), n_ret, m_ret);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
